// File: rtl/mem_arbiter.sv
// mem_arbiter: merges instruction and data request ports onto one memory port,
// round-robin with lock-on-stall, and routes in-order responses back by owner.
module mem_arbiter #(
   parameter int Xlen     = 32,
   parameter int MaskBits = 4,
   parameter int Depth    = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   output logic                inst_ready_o,
   input  logic                inst_valid_i,
   input  logic [Xlen-1:0]     inst_addr_i,
   input  logic [Xlen-1:0]     inst_wdata_i,
   input  logic [MaskBits-1:0] inst_wmask_i,
   output logic [Xlen-1:0]     inst_rdata_o,
   output logic                inst_rvalid_o,
   output logic                data_ready_o,
   input  logic                data_valid_i,
   input  logic [Xlen-1:0]     data_addr_i,
   input  logic [Xlen-1:0]     data_wdata_i,
   input  logic [MaskBits-1:0] data_wmask_i,
   output logic [Xlen-1:0]     data_rdata_o,
   output logic                data_rvalid_o,
   input  logic                mem_ready_i,
   output logic                mem_valid_o,
   output logic [Xlen-1:0]     mem_addr_o,
   output logic [Xlen-1:0]     mem_wdata_o,
   output logic [MaskBits-1:0] mem_wmask_o,
   input  logic [Xlen-1:0]     mem_rdata_i,
   input  logic                mem_rvalid_i,
   output logic                err_o
);
   localparam int Aw = $clog2(Depth);
   localparam int Cw = Aw + 1;

   logic [Depth-1:0] fifo_q, fifo_d;
   logic [Aw-1:0]    rd_q, rd_d, wr_q, wr_d;
   logic [Cw-1:0]    count_q, count_d;
   logic             last_q, last_d, lock_q, lock_d, lock_id_q, lock_id_d, err_q, err_d;
   logic             sel, full, accept, stall, pop, head;

   // Owner encoding: 0 = inst, 1 = data. A stalled grant stays locked until accepted.
   assign sel    = lock_q ? lock_id_q : (inst_valid_i && data_valid_i) ? ~last_q : data_valid_i;
   assign full   = count_q == Cw'(Depth);
   assign mem_valid_o = (sel ? data_valid_i : inst_valid_i) && !full;
   assign mem_addr_o  = sel ? data_addr_i  : inst_addr_i;
   assign mem_wdata_o = sel ? data_wdata_i : inst_wdata_i;
   assign mem_wmask_o = sel ? data_wmask_i : inst_wmask_i;
   assign accept = mem_valid_o && mem_ready_i;
   assign stall  = mem_valid_o && !mem_ready_i;
   assign inst_ready_o = accept && !sel;
   assign data_ready_o = accept && sel;
   assign pop    = mem_rvalid_i && count_q != '0;
   assign head   = fifo_q[rd_q];
   assign inst_rvalid_o = pop && !head;
   assign data_rvalid_o = pop && head;
   assign inst_rdata_o  = mem_rdata_i;
   assign data_rdata_o  = mem_rdata_i;
   assign err_o = err_q;

   always_comb begin
      fifo_d = fifo_q;
      if (accept) fifo_d[wr_q] = sel;
      wr_d      = wr_q + Aw'(accept);
      rd_d      = rd_q + Aw'(pop);
      count_d   = count_q + Cw'(accept) - Cw'(pop);
      last_d    = accept ? sel : last_q;
      lock_d    = accept ? 1'b0 : stall ? 1'b1 : lock_q;
      lock_id_d = stall ? sel : lock_id_q;
      err_d     = err_q || (mem_rvalid_i && count_q == '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fifo_q    <= '0;
         rd_q      <= '0;
         wr_q      <= '0;
         count_q   <= '0;
         last_q    <= 1'b0;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         fifo_q    <= fifo_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         count_q   <= count_d;
         last_q    <= last_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         err_q     <= err_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a queue-based
// model of the arbiter's grant, ownership and error rules.
module tb_mem_arbiter;
   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        iv = 0, dv = 0, mr = 0, rv = 0;
   logic [31:0] ia = 0, iw = 0, da = 0, dw = 0, rd = 0;
   logic [3:0]  im = 0, dm = 0;
   logic        inst_ready_o, inst_rvalid_o, data_ready_o, data_rvalid_o;
   logic        mem_valid_o, err_o;
   logic [31:0] inst_rdata_o, data_rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_wmask_o;

   int passed = 0, total = 0;
   int q[$];
   int last = 0, pend = -1, m_sel = 0;
   bit m_err = 0, e_mv, e_ir, e_dr, e_irv, e_drv;

   always #5 clk_i = ~clk_i;

   mem_arbiter dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .inst_ready_o(inst_ready_o), .inst_valid_i(iv), .inst_addr_i(ia), .inst_wdata_i(iw),
      .inst_wmask_i(im), .inst_rdata_o(inst_rdata_o), .inst_rvalid_o(inst_rvalid_o),
      .data_ready_o(data_ready_o), .data_valid_i(dv), .data_addr_i(da), .data_wdata_i(dw),
      .data_wmask_i(dm), .data_rdata_o(data_rdata_o), .data_rvalid_o(data_rvalid_o),
      .mem_ready_i(mr), .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(rd),
      .mem_rvalid_i(rv), .err_o(err_o)
   );

   // Model: q holds owners of outstanding requests oldest first; pend is a stalled grant.
   function automatic void model_eval();
      m_sel = pend >= 0 ? pend : (iv && dv) ? 1 - last : (dv ? 1 : 0);
      e_mv  = (m_sel == 1 ? dv : iv) && q.size() < 4;
      e_ir  = e_mv && mr && m_sel == 0;
      e_dr  = e_mv && mr && m_sel == 1;
      e_irv = rv && q.size() > 0 && q[0] == 0;
      e_drv = rv && q.size() > 0 && q[0] == 1;
   endfunction

   task automatic step();
      model_eval();
      @(posedge clk_i);
      if (rv && q.size() == 0) m_err = 1;
      if (rv && q.size() > 0) void'(q.pop_front());
      if (e_mv && mr) begin
         q.push_back(m_sel);
         last = m_sel;
         pend = -1;
      end else if (e_mv) pend = m_sel;
      #1;
   endtask

   task automatic do_reset();
      rst_ni = 0; iv = 0; dv = 0; mr = 0; rv = 0;
      q.delete(); last = 0; pend = -1; m_err = 0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (mem_valid_o !== 1'b0) $display("FAIL reset_mem_valid got %b exp 0", mem_valid_o); else passed++;
      total++; if (inst_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) $display("FAIL reset_rvalid got %b%b exp 00", inst_rvalid_o, data_rvalid_o); else passed++;
      total++; if (inst_ready_o !== 1'b0 || data_ready_o !== 1'b0) $display("FAIL reset_ready got %b%b exp 00", inst_ready_o, data_ready_o); else passed++;
      total++; if (err_o !== 1'b0) $display("FAIL reset_err got %b exp 0", err_o); else passed++;
   endtask

   task automatic test_single_inst();
      do_reset();
      iv = 1; ia = 32'h0; mr = 1; #1;
      total++; if (mem_addr_o !== 32'h0 || inst_ready_o !== 1'b1) $display("FAIL single_req got addr %h rdy %b exp 0 1", mem_addr_o, inst_ready_o); else passed++;
      step();
      iv = 0; rv = 1; rd = 32'h00500093; #1;
      total++; if (inst_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) $display("FAIL single_rsp got %b%b exp 10", inst_rvalid_o, data_rvalid_o); else passed++;
      total++; if (inst_rdata_o !== 32'h00500093) $display("FAIL single_rdata got %h exp 00500093", inst_rdata_o); else passed++;
      step();
      rv = 0;
   endtask

   task automatic test_alternate();
      logic exp_d;
      do_reset();
      iv = 1; dv = 1; mr = 1; ia = 32'h1000; da = 32'h2000;
      for (int k = 0; k < 4; k++) begin
         rv = k > 0; exp_d = (k % 2) == 0; #1;
         total++; if (data_ready_o !== exp_d || inst_ready_o !== !exp_d) $display("FAIL alt_grant%0d got d%b i%b exp d%b", k, data_ready_o, inst_ready_o, exp_d); else passed++;
         total++; if (mem_addr_o !== (exp_d ? da : ia)) $display("FAIL alt_addr%0d got %h exp %h", k, mem_addr_o, exp_d ? da : ia); else passed++;
         if (k > 0) begin
            total++; if (data_rvalid_o !== !exp_d || inst_rvalid_o !== exp_d) $display("FAIL alt_rsp%0d got d%b i%b exp d%b", k, data_rvalid_o, inst_rvalid_o, !exp_d); else passed++;
         end
         step();
      end
      iv = 0; dv = 0; rv = 1; #1;
      total++; if (inst_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) $display("FAIL alt_last_rsp got i%b d%b exp i1 d0", inst_rvalid_o, data_rvalid_o); else passed++;
      step();
      rv = 0;
   endtask

   task automatic test_stall();
      do_reset();
      dv = 1; da = 32'h50; dm = 4'h0; mr = 1; #1;
      total++; if (data_ready_o !== 1'b1) $display("FAIL stall_pre got %b exp 1", data_ready_o); else passed++;
      step();
      da = 32'h100; dm = 4'hF; dw = 32'hDEADBEEF; ia = 32'h200; mr = 0;
      for (int c = 0; c < 3; c++) begin
         iv = c > 0; #1;
         total++; if (mem_valid_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_wmask_o !== 4'hF) $display("FAIL stall_hold%0d got v%b %h %h exp v1 100 f", c, mem_valid_o, mem_addr_o, mem_wmask_o); else passed++;
         total++; if (inst_ready_o !== 1'b0 || data_ready_o !== 1'b0) $display("FAIL stall_ready%0d got i%b d%b exp 00", c, inst_ready_o, data_ready_o); else passed++;
         step();
      end
      mr = 1; #1;
      total++; if (data_ready_o !== 1'b1 || inst_ready_o !== 1'b0 || mem_addr_o !== 32'h100) $display("FAIL stall_accept got d%b i%b %h exp d1 i0 100", data_ready_o, inst_ready_o, mem_addr_o); else passed++;
      step();
      dv = 0; #1;
      total++; if (inst_ready_o !== 1'b1 || mem_addr_o !== 32'h200) $display("FAIL stall_next got i%b %h exp i1 200", inst_ready_o, mem_addr_o); else passed++;
      step();
      iv = 0;
   endtask

   task automatic test_full();
      do_reset();
      iv = 1; mr = 1; ia = 32'h40;
      for (int n = 0; n < 4; n++) begin
         #1;
         total++; if (inst_ready_o !== 1'b1) $display("FAIL full_fill%0d got %b exp 1", n, inst_ready_o); else passed++;
         step();
      end
      #1;
      total++; if (mem_valid_o !== 1'b0 || inst_ready_o !== 1'b0) $display("FAIL full_block got v%b r%b exp 00", mem_valid_o, inst_ready_o); else passed++;
      step();
      rv = 1; #1;
      total++; if (inst_rvalid_o !== 1'b1 || inst_ready_o !== 1'b0) $display("FAIL full_pop got rv%b r%b exp 10", inst_rvalid_o, inst_ready_o); else passed++;
      step();
      rv = 0; #1;
      total++; if (inst_ready_o !== 1'b1) $display("FAIL full_refill got %b exp 1", inst_ready_o); else passed++;
      step();
      #1;
      total++; if (inst_ready_o !== 1'b0) $display("FAIL full_again got %b exp 0", inst_ready_o); else passed++;
      step();
      iv = 0;
   endtask

   task automatic test_push_pop();
      do_reset();
      mr = 1; iv = 1; #1;
      step();
      iv = 0; dv = 1; #1;
      step();
      dv = 0; iv = 1; rv = 1; #1;
      total++; if (inst_ready_o !== 1'b1 || inst_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) $display("FAIL pp_both got r%b i%b d%b exp 110", inst_ready_o, inst_rvalid_o, data_rvalid_o); else passed++;
      step();
      iv = 0; #1;
      total++; if (data_rvalid_o !== 1'b1 || inst_rvalid_o !== 1'b0) $display("FAIL pp_pop2 got d%b i%b exp d1 i0", data_rvalid_o, inst_rvalid_o); else passed++;
      step();
      #1;
      total++; if (inst_rvalid_o !== 1'b1 || data_rvalid_o !== 1'b0) $display("FAIL pp_pop3 got i%b d%b exp i1 d0", inst_rvalid_o, data_rvalid_o); else passed++;
      step();
      #1;
      total++; if (inst_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) $display("FAIL pp_empty got i%b d%b exp 00", inst_rvalid_o, data_rvalid_o); else passed++;
      step();
      rv = 0;
   endtask

   task automatic test_err();
      do_reset();
      rv = 1; #1;
      total++; if (inst_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) $display("FAIL err_drop got i%b d%b exp 00", inst_rvalid_o, data_rvalid_o); else passed++;
      step();
      rv = 0; #1;
      total++; if (err_o !== 1'b1) $display("FAIL err_set got %b exp 1", err_o); else passed++;
      repeat (3) step();
      rv = 1; iv = 1; mr = 1; #1;
      total++; if (inst_rvalid_o !== 1'b0 || inst_ready_o !== 1'b1) $display("FAIL err_push got rv%b r%b exp 01", inst_rvalid_o, inst_ready_o); else passed++;
      step();
      rv = 0; iv = 0; #1;
      total++; if (err_o !== 1'b1) $display("FAIL err_sticky got %b exp 1", err_o); else passed++;
      rst_ni = 0; #1;
      total++; if (err_o !== 1'b0 || mem_valid_o !== 1'b0) $display("FAIL err_clear got e%b v%b exp 00", err_o, mem_valid_o); else passed++;
      do_reset();
   endtask

   task automatic test_random();
      bit acc_i = 0, acc_d = 0;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         if (!iv || acc_i) begin iv = 1'($urandom); ia = $urandom; iw = $urandom; im = 4'($urandom); end
         if (!dv || acc_d) begin dv = 1'($urandom); da = $urandom; dw = $urandom; dm = 4'($urandom); end
         mr = $urandom_range(0, 3) != 0;
         rv = q.size() > 0 && $urandom_range(0, 1) == 1;
         rd = $urandom;
         #1;
         model_eval();
         total++; if ({mem_valid_o, inst_ready_o, data_ready_o} !== {e_mv, e_ir, e_dr}) $display("FAIL rnd_req%0d got %b%b%b exp %b%b%b", n, mem_valid_o, inst_ready_o, data_ready_o, e_mv, e_ir, e_dr); else passed++;
         total++; if ({inst_rvalid_o, data_rvalid_o} !== {e_irv, e_drv}) $display("FAIL rnd_rsp%0d got %b%b exp %b%b", n, inst_rvalid_o, data_rvalid_o, e_irv, e_drv); else passed++;
         total++; if (inst_rdata_o !== rd || data_rdata_o !== rd) $display("FAIL rnd_rdata%0d got %h %h exp %h", n, inst_rdata_o, data_rdata_o, rd); else passed++;
         total++; if (err_o !== m_err) $display("FAIL rnd_err%0d got %b exp %b", n, err_o, m_err); else passed++;
         if (e_mv) begin
            total++; if ({mem_addr_o, mem_wdata_o, mem_wmask_o} !== (m_sel == 1 ? {da, dw, dm} : {ia, iw, im})) $display("FAIL rnd_fields%0d got %h %h %h sel %0d", n, mem_addr_o, mem_wdata_o, mem_wmask_o, m_sel); else passed++;
         end
         acc_i = e_ir; acc_d = e_dr;
         step();
      end
      iv = 0; dv = 0; rv = 0;
   endtask

   initial begin
      test_reset();
      test_single_inst();
      test_alternate();
      test_stall();
      test_full();
      test_push_pop();
      test_err();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
